// File: rtl/game_core_pkg.sv
// Shared constants for the scrolling beam game: FSM encodings, LFSR seed/taps
// and the default playfield parameters.
package game_core_pkg;

  localparam logic [1:0] ST_CALIB = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_OVER  = 2'b10;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int DEF_GW           = 8;
  localparam int DEF_GH           = 8;
  localparam int DEF_GAP          = 2;
  localparam int DEF_SCROLL_DIV   = 16;
  localparam int DEF_BEAM_SPACING = 4;
  localparam int DEF_SCORE_W      = 8;
  localparam int DEF_WALL_KILL    = 1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes the low byte used for gap placement.
module game_lfsr
  import game_core_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  output logic [7:0] rnd_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign rnd_o = lfsr_q[7:0];

endmodule

// File: rtl/game_core.sv
// Side-scrolling beam game: bird in column 0 dodges beams that scroll in from
// the right; frame, score and FSM state are registered outputs.
module game_core
  import game_core_pkg::*;
#(
  parameter int GW           = DEF_GW,
  parameter int GH           = DEF_GH,
  parameter int GAP          = DEF_GAP,
  parameter int SCROLL_DIV   = DEF_SCROLL_DIV,
  parameter int BEAM_SPACING = DEF_BEAM_SPACING,
  parameter int SCORE_W      = DEF_SCORE_W,
  parameter int WALL_KILL    = DEF_WALL_KILL
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 up_i,
  input  logic                 down_i,
  input  logic                 e_act_i,
  output logic [GW*GH-1:0]     matrix_o,
  output logic                 d_act_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [1:0]           state_o
);

  // Strobe protocol: every cycle with e_act_i=1 is one game step (no back-
  // pressure); d_act_o is high exactly on the following cycle to mark a fresh frame.

  localparam int RW = (GH > 1) ? $clog2(GH) : 1;
  localparam int NG = GH - GAP + 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW = $clog2(BEAM_SPACING);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [RW-1:0]      START_ROW   = RW'(GH/2 - 1);
  localparam logic [GW*GH-1:0]   START_FRAME = {{(GW*GH-1){1'b0}}, 1'b1} << (GH/2 - 1);

  logic [1:0]         state_q, state_d;
  logic [GW*GH-1:0]   beams_q, beams_d;
  logic [GW*GH-1:0]   matrix_q, matrix_d;
  logic [RW-1:0]      row_q, row_d;
  logic [SW-1:0]      scroll_q, scroll_d;
  logic [BW-1:0]      space_q, space_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               up_hist_q;
  logic               d_act_q;
  logic [7:0]         rnd;

  game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (1'b1),
    .rnd_o   (rnd)
  );

  logic [GW*GH-1:0] diag_frame;
  always_comb begin
    diag_frame = '0;
    for (int c = 0; c < GW; c++) begin
      if (c < GH) diag_frame[c*GH + c] = 1'b1;
    end
  end

  logic [7:0]    gap_base;
  logic [GH-1:0] beam_col;
  assign gap_base = rnd % 8'(NG);

  always_comb begin
    beam_col = '1;
    for (int r = 0; r < GH; r++) begin
      if (r >= int'(gap_base) && r < int'(gap_base) + GAP) beam_col[r] = 1'b0;
    end
  end

  // Bird movement; an edge attempt leaves the row where it is.
  logic          want_up, want_down, at_edge, kill;
  logic [RW-1:0] row_mv;
  assign want_up   = up_i & ~down_i;
  assign want_down = down_i & ~up_i;
  assign at_edge   = (want_up && row_q == RW'(GH-1)) || (want_down && row_q == '0);
  assign kill      = at_edge && (WALL_KILL != 0);

  always_comb begin
    row_mv = row_q;
    if (!at_edge) begin
      if (want_up)        row_mv = row_q + 1'b1;
      else if (want_down) row_mv = row_q - 1'b1;
    end
  end

  logic             scroll_now, collide, passed;
  logic [GH-1:0]    refill, bird_col;
  logic [GW*GH-1:0] beams_mv;
  assign scroll_now = (scroll_q == SW'(SCROLL_DIV - 1));
  assign refill     = (space_q == '0) ? beam_col : '0;
  assign beams_mv   = scroll_now ? {refill, beams_q[GW*GH-1:GH]} : beams_q;
  assign bird_col   = {{(GH-1){1'b0}}, 1'b1} << row_mv;
  assign collide    = |(beams_mv[GH-1:0] & bird_col);
  assign passed     = scroll_now && (|beams_q[GH-1:0]);

  always_comb begin
    state_d  = state_q;
    beams_d  = beams_q;
    matrix_d = matrix_q;
    row_d    = row_q;
    scroll_d = scroll_q;
    space_d  = space_q;
    score_d  = score_q;
    if (e_act_i) begin
      case (state_q)
        ST_CALIB: begin
          matrix_d = diag_frame;
          if (up_i) begin
            state_d  = ST_PLAY;
            beams_d  = '0;
            matrix_d = START_FRAME;
            row_d    = START_ROW;
            scroll_d = '0;
            space_d  = '0;
            score_d  = '0;
          end
        end
        ST_PLAY: begin
          row_d    = row_mv;
          beams_d  = beams_mv;
          matrix_d = beams_mv | {{(GW*GH-GH){1'b0}}, bird_col};
          if (scroll_now) begin
            scroll_d = '0;
            space_d  = (space_q == BW'(BEAM_SPACING - 1)) ? '0 : space_q + 1'b1;
          end else begin
            scroll_d = scroll_q + 1'b1;
          end
          if (kill || collide) begin
            state_d = ST_OVER;
          end else if (passed && score_q != SCORE_MAX) begin
            score_d = score_q + 1'b1;
          end
        end
        ST_OVER: begin
          // Restart only on a fresh press so a held button cannot chain games.
          if (up_i && !up_hist_q) begin
            state_d  = ST_PLAY;
            beams_d  = '0;
            matrix_d = START_FRAME;
            row_d    = START_ROW;
            scroll_d = '0;
            space_d  = '0;
            score_d  = '0;
          end
        end
        default: state_d = ST_CALIB;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_CALIB;
      beams_q   <= '0;
      matrix_q  <= '0;
      row_q     <= '0;
      scroll_q  <= '0;
      space_q   <= '0;
      score_q   <= '0;
      up_hist_q <= 1'b1;
      d_act_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      beams_q   <= beams_d;
      matrix_q  <= matrix_d;
      row_q     <= row_d;
      scroll_q  <= scroll_d;
      space_q   <= space_d;
      score_q   <= score_d;
      d_act_q   <= e_act_i;
      if (e_act_i) up_hist_q <= up_i;
    end
  end

  assign matrix_o = matrix_q;
  assign d_act_o  = d_act_q;
  assign score_o  = score_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_game_core.sv
// Directed bench for game_core: two instances differing only in WALL_KILL,
// driven by the same inputs, with an LFSR model predicting beam gaps.
module tb_game_core;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        up_i = 1'b0;
  logic        down_i = 1'b0;
  logic        e_act_i = 1'b0;
  logic [63:0] matrix_k, matrix_s;
  logic        d_act_k, d_act_s;
  logic [7:0]  score_k, score_s;
  logic [1:0]  state_k, state_s;

  int errors = 0;
  int checks = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  exp_q[$];
  int          bird_row;

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_i) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  game_core #(.GW(8), .GH(8), .GAP(2), .SCROLL_DIV(1), .BEAM_SPACING(8),
              .SCORE_W(8), .WALL_KILL(1)) dut_k (
    .clk_i(clk), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .e_act_i(e_act_i),
    .matrix_o(matrix_k), .d_act_o(d_act_k), .score_o(score_k), .state_o(state_k)
  );

  game_core #(.GW(8), .GH(8), .GAP(2), .SCROLL_DIV(1), .BEAM_SPACING(8),
              .SCORE_W(8), .WALL_KILL(0)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .up_i(up_i), .down_i(down_i), .e_act_i(e_act_i),
    .matrix_o(matrix_s), .d_act_o(d_act_s), .score_o(score_s), .state_o(state_s)
  );

  // driver tasks
  task automatic apply_reset();
    @(negedge clk);
    reset_i = 1'b1; e_act_i = 1'b0; up_i = 1'b0; down_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic drive_step(input logic u, input logic d);
    up_i = u; down_i = d; e_act_i = 1'b1;
    @(posedge clk); #1;
    e_act_i = 1'b0; up_i = 1'b0; down_i = 1'b0;
  endtask

  task automatic do_step(input logic u, input logic d);
    @(negedge clk);
    drive_step(u, d);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (state_k !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state_k); end
    checks++; if (matrix_k !== 64'h0) begin errors++; $display("FAIL reset_matrix: got %h want 0", matrix_k); end
    checks++; if (score_k !== 8'h0) begin errors++; $display("FAIL reset_score: got %0d want 0", score_k); end
    checks++; if (d_act_k !== 1'b1) begin errors++; $display("FAIL reset_dact: got %b want 1", d_act_k); end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      do_step(1'b0, 1'b0);
      checks++; if (d_act_k !== 1'b1) begin errors++; $display("FAIL calib_dact_hi: step %0d got %b want 1", i, d_act_k); end
      @(posedge clk); #1;
      checks++; if (d_act_k !== 1'b0) begin errors++; $display("FAIL calib_dact_lo: step %0d got %b want 0", i, d_act_k); end
    end
    checks++; if (state_k !== 2'b00) begin errors++; $display("FAIL calib_state: got %b want 00", state_k); end
    checks++; if (matrix_k !== 64'h8040201008040201) begin errors++; $display("FAIL calib_diag: got %h want 8040201008040201", matrix_k); end
  endtask

  task automatic test_start();
    logic [7:0] g;
    logic [7:0] col;
    do_step(1'b1, 1'b0);
    checks++; if (state_k !== 2'b01) begin errors++; $display("FAIL start_state: got %b want 01", state_k); end
    checks++; if (matrix_k !== 64'h8) begin errors++; $display("FAIL start_frame: got %h want 8", matrix_k); end
    checks++; if (score_k !== 8'h0) begin errors++; $display("FAIL start_score: got %0d want 0", score_k); end
    @(negedge clk);
    g = m_lfsr[7:0] % 8'd7;
    col = ~(8'h03 << g);
    drive_step(1'b1, 1'b0);
    checks++; if (matrix_k[7:0] !== 8'h10) begin errors++; $display("FAIL move_up: got %h want 10", matrix_k[7:0]); end
    checks++; if (matrix_k[63:56] !== col) begin errors++; $display("FAIL first_beam: got %h want %h", matrix_k[63:56], col); end
  endtask

  task automatic test_wall();
    logic [63:0] frozen;
    for (int i = 0; i < 3; i++) do_step(1'b1, 1'b0);
    do_step(1'b1, 1'b0);
    checks++; if (state_k !== 2'b10) begin errors++; $display("FAIL wall_kill_state: got %b want 10", state_k); end
    checks++; if (matrix_k[7:0] !== 8'h80) begin errors++; $display("FAIL wall_kill_row: got %h want 80", matrix_k[7:0]); end
    checks++; if (state_s !== 2'b01) begin errors++; $display("FAIL wall_sat_state: got %b want 01", state_s); end
    checks++; if (matrix_s[7:0] !== 8'h80) begin errors++; $display("FAIL wall_sat_row: got %h want 80", matrix_s[7:0]); end
    frozen = matrix_k;
    do_step(1'b1, 1'b0);
    checks++; if (state_k !== 2'b10) begin errors++; $display("FAIL over_held_up: got %b want 10", state_k); end
    checks++; if (matrix_k !== frozen) begin errors++; $display("FAIL over_frozen: got %h want %h", matrix_k, frozen); end
    do_step(1'b0, 1'b0);
    do_step(1'b1, 1'b0);
    checks++; if (state_k !== 2'b01) begin errors++; $display("FAIL restart_state: got %b want 01", state_k); end
    checks++; if (matrix_k !== 64'h8) begin errors++; $display("FAIL restart_frame: got %h want 8", matrix_k); end
  endtask

  task automatic test_collision();
    logic [7:0] g0;
    logic [1:0] exp_st;
    logic [7:0] exp_c0;
    apply_reset();
    release_reset();
    do_step(1'b1, 1'b0);
    g0 = 8'h0;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      if (s == 1) g0 = m_lfsr[7:0] % 8'd7;
      drive_step(1'b0, 1'b0);
      if (s == 7) begin
        checks++; if (state_k !== 2'b01) begin errors++; $display("FAIL pre_collide_state: got %b want 01", state_k); end
      end
    end
    exp_st = (g0 == 8'd2 || g0 == 8'd3) ? 2'b01 : 2'b10;
    exp_c0 = ~(8'h03 << g0) | 8'h08;
    checks++; if (state_k !== exp_st) begin errors++; $display("FAIL collide_state: got %b want %b gap %0d", state_k, exp_st, g0); end
    checks++; if (score_k !== 8'h0) begin errors++; $display("FAIL collide_score: got %0d want 0", score_k); end
    checks++; if (matrix_k[7:0] !== exp_c0) begin errors++; $display("FAIL collide_col0: got %h want %h", matrix_k[7:0], exp_c0); end
  endtask

  task automatic test_track();
    int tgt;
    logic u, d;
    logic [7:0] bird;
    apply_reset();
    release_reset();
    exp_q.delete();
    do_step(1'b1, 1'b0);
    bird_row = 3;
    for (int s = 1; s <= 26; s++) begin
      @(negedge clk);
      if ((s - 1) % 8 == 0) exp_q.push_back(m_lfsr[7:0] % 8'd7);
      tgt = int'(exp_q[0]);
      u = 1'b0; d = 1'b0;
      if (s == 26) begin
        u = 1'b1; d = 1'b1;
      end else if (bird_row < tgt) begin
        u = 1'b1; bird_row++;
      end else if (bird_row > tgt + 1) begin
        d = 1'b1; bird_row--;
      end
      drive_step(u, d);
      if (s % 8 == 0) begin
        exp_q.delete(0);
        checks++; if (state_k !== 2'b01) begin errors++; $display("FAIL track_pass_state: step %0d got %b want 01", s, state_k); end
      end
      if (s == 9) begin
        checks++; if (score_k !== 8'd1) begin errors++; $display("FAIL score_one: got %0d want 1", score_k); end
      end
      if (s == 25) begin
        checks++; if (score_k !== 8'd3) begin errors++; $display("FAIL score_three: got %0d want 3", score_k); end
        checks++; if (score_s !== 8'd3) begin errors++; $display("FAIL score_three_s: got %0d want 3", score_s); end
      end
    end
    bird = 8'h01 << bird_row;
    checks++; if (matrix_k[7:0] !== bird) begin errors++; $display("FAIL both_pressed: got %h want %h", matrix_k[7:0], bird); end
    checks++; if (state_k !== 2'b01) begin errors++; $display("FAIL track_state: got %b want 01", state_k); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    reset_i = 1'b1; e_act_i = 1'b1; up_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (state_k !== 2'b00) begin errors++; $display("FAIL mid_reset_state: got %b want 00", state_k); end
    checks++; if (matrix_k !== 64'h0) begin errors++; $display("FAIL mid_reset_matrix: got %h want 0", matrix_k); end
    checks++; if (score_k !== 8'h0) begin errors++; $display("FAIL mid_reset_score: got %0d want 0", score_k); end
    @(negedge clk);
    reset_i = 1'b0; e_act_i = 1'b0; up_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_wall();
    test_collision();
    test_track();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
